// File: rtl/vc_qspi_mem_resp.sv
// Quad-SPI memory responder: decodes quad read (0xEB) and quad write (0x38)
// transactions, oversampled in the clk domain, into byte accesses on an SRAM port.
module vc_qspi_mem_resp #(
    parameter int AW    = 22,
    parameter int DUMMY = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic [3:0]    sd_in,
    output logic [3:0]    sd_out,
    output logic [3:0]    sd_oe,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_IGNORE
    } state_t;

    localparam logic [3:0] DUMMY_CNT = 4'(DUMMY);

    state_t        r_state, w_next;
    logic          r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic          r_cs_s1, r_cs_s2;
    logic [3:0]    r_sd_s1, r_sd_s2;
    logic [19:0]   r_shift;
    logic [2:0]    r_cnt;
    logic [3:0]    r_dcnt;
    logic          r_is_read;
    logic          r_half;
    logic [7:0]    r_rbyte;
    logic [3:0]    r_sd_out;
    logic          r_sd_oe;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_wdata;
    logic          r_we, r_re;

    logic          w_rise, w_fall, w_abort;
    logic [7:0]    w_byte;

    // The cs_n synchronizer resets to 1 so reset never looks like a selected bus.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_sd_s1   <= 4'h0;
            r_sd_s2   <= 4'h0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= cs_n;
            r_cs_s2   <= r_cs_s1;
            r_sd_s1   <= sd_in;
            r_sd_s2   <= r_sd_s1;
        end
    end

    assign w_rise  = r_sclk_s2 & ~r_sclk_d;
    assign w_fall  = ~r_sclk_s2 & r_sclk_d;
    assign w_abort = r_cs_s2 && (r_state != S_IDLE);
    assign w_byte  = {r_shift[3:0], r_sd_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: next state is defaulted first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!r_cs_s2) w_next = S_CMD;
            S_CMD:   if (w_rise && r_cnt == 3'd1)
                         w_next = (w_byte == 8'h38 || w_byte == 8'hEB) ? S_ADDR : S_IGNORE;
            S_ADDR:  if (w_rise && r_cnt == 3'd5)
                         w_next = r_is_read ? S_DUMMY : S_WDATA;
            S_DUMMY: if (w_fall && r_dcnt == DUMMY_CNT) w_next = S_RDATA;
            default: w_next = r_state;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_dcnt      <= '0;
            r_is_read   <= 1'b0;
            r_half      <= 1'b0;
            r_rbyte     <= '0;
            r_sd_out    <= '0;
            r_sd_oe     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            // Write address advances only after the strobe so it is stable during mem_we.
            if (r_we) r_mem_addr <= r_mem_addr + AW'(1);

            if (w_abort) begin
                r_sd_oe <= 1'b0;
                r_cnt   <= '0;
                r_dcnt  <= '0;
                r_half  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt  <= '0;
                        r_dcnt <= '0;
                        r_half <= 1'b0;
                    end
                    S_CMD: if (w_rise) begin
                        r_shift <= {r_shift[15:0], r_sd_s2};
                        if (r_cnt == 3'd1) begin
                            r_cnt     <= '0;
                            r_is_read <= (w_byte == 8'hEB);
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    S_ADDR: if (w_rise) begin
                        r_shift <= {r_shift[15:0], r_sd_s2};
                        if (r_cnt == 3'd5) begin
                            r_cnt      <= '0;
                            r_mem_addr <= AW'({r_shift, r_sd_s2});
                            r_re       <= r_is_read;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    S_WDATA: if (w_rise) begin
                        if (r_cnt[0]) begin
                            r_mem_wdata <= w_byte;
                            r_we        <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_shift <= {r_shift[15:0], r_sd_s2};
                            r_cnt   <= 3'd1;
                        end
                    end
                    S_DUMMY: begin
                        if (w_rise && r_dcnt != DUMMY_CNT) r_dcnt <= r_dcnt + 4'd1;
                        if (w_fall && r_dcnt == DUMMY_CNT) begin
                            r_rbyte  <= mem_rdata;
                            r_sd_out <= mem_rdata[7:4];
                            r_sd_oe  <= 1'b1;
                            r_half   <= 1'b1;
                        end
                    end
                    S_RDATA: if (w_fall) begin
                        if (r_half) begin
                            // Prefetch the next byte while its predecessor's low nibble is out.
                            r_sd_out   <= r_rbyte[3:0];
                            r_mem_addr <= r_mem_addr + AW'(1);
                            r_re       <= 1'b1;
                            r_half     <= 1'b0;
                        end else begin
                            r_rbyte  <= mem_rdata;
                            r_sd_out <= mem_rdata[7:4];
                            r_half   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sd_out    = r_sd_out;
    assign sd_oe     = {4{r_sd_oe}};
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_we;
    assign mem_re    = r_re;

endmodule

// File: doc/vc_qspi_mem_resp.md
# vc_qspi_mem_resp

Quad-SPI memory responder: the far end of the vc32 CPU's external serial memory bus on the TinyTapeout pins. It decodes quad read and quad write transactions from the CPU-side initiator and turns them into byte accesses on a simple synchronous SRAM-style port. It is used in the FPGA/emulation build and the verification bench as the backing memory for the 22-bit physical address space. SCLK, CS_N and data are oversampled in the system clock domain.

## Interface
- AW, 22: memory address width; command address bits above AW-1 are ignored.
- DUMMY, 6: read turnaround, in SCLK cycles; legal range 1..15.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from the initiator, mode 0, idle low.
- cs_n  in  1  chip select from the initiator, active low.
- sd_in  in  4  quad data from the initiator.
- sd_out  out  4  quad data to the initiator.
- sd_oe  out  4  output enable for sd_out; all bits are equal.
- mem_addr  out  AW  byte address.
- mem_wdata  out  8  write byte.
- mem_we  out  1  one-clk write strobe.
- mem_re  out  1  one-clk read strobe.
- mem_rdata  in  8  read data; valid on the clk after mem_re.

## Operation
- Synchronizers: sclk, cs_n and sd_in each pass through a 2-flop synchronizer. A rise or fall event is a 0->1 or 1->0 change on the synchronized sclk. Input nibbles are sampled on rise events only.
- States:
  - IDLE: waits for synchronized cs_n=0, then -> CMD.
  - CMD: 2 nibbles, MSB first.
    - 0x38 -> ADDR (write).
    - 0xEB -> ADDR (read).
    - Any other value -> IGNORE.
  - ADDR: 6 nibbles form a 24-bit address, MSB first. mem_addr is loaded with addr[AW-1:0].
    - Write: -> WDATA.
    - Read: pulse mem_re, then -> DUMMY.
  - WDATA: on every 2nd nibble (high nibble first), pulse mem_we with the assembled byte, then increment mem_addr.
  - DUMMY: counts DUMMY rise events. On the fall event after the last one: latch mem_rdata into the shift byte, drive its high nibble, assert sd_oe, and -> RDATA.
  - RDATA: each fall event drives the next nibble.
    - On driving a low nibble: increment mem_addr and pulse mem_re.
    - On the fall event after that: latch the new mem_rdata and drive its high nibble.
  - IGNORE: holds sd_oe=0 and ignores all input until cs_n rises.
- Address increment wraps modulo 2^AW; 0x3FFFFF+1 -> 0x000000 at AW=22.
- A synchronized cs_n rise in any state:
  - Next state is IDLE.
  - sd_oe=0 on the next clk.
  - Any partial write byte is discarded, with no mem_we.
  - An in-flight mem_rdata is dropped.
- cs_n=1 in IDLE ignores sclk activity.
- A write continues until cs_n rises. There is no length limit.

## Timing
- Reset values: sd_out=0, sd_oe=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0. State=IDLE; all counters and synchronizers are 0, except the cs_n synchronizer, which resets to 1.
- SCLK frequency must be at most clk/4. SCLK high and low phases must each be at least 2 clk.
- Input latency: a sclk edge at the pin becomes a detected event 3 clk later (2 synchronizer flops plus the edge register).
- mem_we and mem_re assert on the clk after the event that completes a byte or address. Each is high for exactly 1 clk. The two are never high together.
- mem_wdata and mem_addr are stable while mem_we=1.
- sd_out changes only on the clk after a fall event. It is therefore stable across the following initiator rise edge.
- First read nibble appears on the (DUMMY+1)th fall event after the last address nibble.
- Read latency margin: mem_re to use of mem_rdata is at least 2 clk. This holds because DUMMY is at least 1 and sclk is at most clk/4.
- sd_oe drops 1 clk after the synchronized cs_n rise, which is 3 clk after the pin edge.

## Test plan
- Reset: pulse rst_n low mid-transaction -> all outputs 0 immediately (asynchronously), and state is IDLE after release.
- Quad write: cmd 0x38, addr 0x001234, data 0xA5 0x3C -> two mem_we pulses: (0x1234, 0xA5) then (0x1235, 0x3C).
- Quad read, DUMMY=6: memory holds 0x5A at 0x000100 and 0xC3 at 0x000101. Send cmd 0xEB, addr 0x000100 -> after 6 dummy cycles, sd_out nibbles 5, A, C, 3 with sd_oe=1; mem_re pulses at 0x100 and 0x101.
- Wrap: write to 0xFFFFFF (truncated to 0x3FFFFF), then a second byte -> the second mem_we is at mem_addr 0x000000.
- Abort: raise cs_n after 1 data nibble of a write -> no mem_we, and state is IDLE. A following write transaction works normally.
- Unknown cmd 0x9F followed by 10 nibbles -> no mem_we, no mem_re, sd_oe stays 0.
